// File: rtl/bit_stuff_serializer.sv
// LSB-first byte serializer with valid/ready input; the line idles high.
// Define BIT_STUFF_EN to insert a 0 after every run of five consecutive data 1s.
module bit_stuff_serializer (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       dv,
  output logic       rdy,
  output logic       so,
  output logic       busy
);

`ifdef BIT_STUFF_EN
  typedef enum logic [1:0] {IDLE, SHIFT, STUFF} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t     state, state_nx;
  logic [7:0] shreg, shreg_nx;
  logic [2:0] bcnt, bcnt_nx;
`ifdef BIT_STUFF_EN
  logic [2:0] ones, ones_nx;
  logic       last, last_nx;
`endif

  // State registers; an asynchronous reset drops any partial byte at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      shreg <= 8'h00;
      bcnt  <= 3'd0;
`ifdef BIT_STUFF_EN
      ones  <= 3'd0;
      last  <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      shreg <= shreg_nx;
      bcnt  <= bcnt_nx;
`ifdef BIT_STUFF_EN
      ones  <= ones_nx;
      last  <= last_nx;
`endif
    end
  end

  // Next-state and output logic. A byte end (bit 7, or a stuff bit following
  // bit 7) is the only point where a new byte can be loaded without a gap.
  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    bcnt_nx  = bcnt;
    so       = 1'b1;
    busy     = 1'b0;
    rdy      = 1'b0;
`ifdef BIT_STUFF_EN
    ones_nx  = ones;
    last_nx  = last;
`endif
    case (state)
      IDLE: begin
        rdy = 1'b1;
        if (dv) begin
          shreg_nx = din;
          bcnt_nx  = 3'd0;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        so   = shreg[0];
        busy = 1'b1;
`ifdef BIT_STUFF_EN
        ones_nx = shreg[0] ? ones + 3'd1 : 3'd0;
        if (shreg[0] && (ones == 3'd4)) begin
          state_nx = STUFF;
          last_nx  = (bcnt == 3'd7);
        end else
`endif
        if (bcnt != 3'd7) begin
          shreg_nx = {1'b0, shreg[7:1]};
          bcnt_nx  = bcnt + 3'd1;
        end else begin
          rdy = 1'b1;
          if (dv) begin
            shreg_nx = din;
            bcnt_nx  = 3'd0;
          end else begin
            state_nx = IDLE;
`ifdef BIT_STUFF_EN
            ones_nx  = 3'd0;
`endif
          end
        end
      end
`ifdef BIT_STUFF_EN
      // Stuffed 0 breaks the run, so the ones counter restarts here.
      STUFF: begin
        so      = 1'b0;
        busy    = 1'b1;
        ones_nx = 3'd0;
        if (last) begin
          rdy = 1'b1;
          if (dv) begin
            shreg_nx = din;
            bcnt_nx  = 3'd0;
            state_nx = SHIFT;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          shreg_nx = {1'b0, shreg[7:1]};
          bcnt_nx  = bcnt + 3'd1;
          state_nx = SHIFT;
        end
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bit_stuff_serializer.sv
// Scoreboard bench for bit_stuff_serializer: expected line bits and rdy per cycle
// are queued from a reference model when bytes are issued, then checked each cycle.
module tb_bit_stuff_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       dv;
  logic       rdy;
  logic       so;
  logic       busy;

  int total = 0;
  int bad   = 0;

  logic exp_so_q[$];
  logic exp_rdy_q[$];

  bit_stuff_serializer dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .dv   (dv),
    .rdy  (rdy),
    .so   (so),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference model: queue the line bits of a byte stream started from idle.
  task automatic push_model(input int n, input logic [7:0] bytes [3]);
    int ones_m;
    logic bitv;
    logic stuff;
    ones_m = 0;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 8; i++) begin
        bitv  = bytes[k][i];
        stuff = 1'b0;
`ifdef BIT_STUFF_EN
        ones_m = bitv ? ones_m + 1 : 0;
        if (ones_m == 5) begin
          stuff  = 1'b1;
          ones_m = 0;
        end
`endif
        exp_so_q.push_back(bitv);
        exp_rdy_q.push_back((i == 7) && !stuff);
        if (stuff) begin
          exp_so_q.push_back(1'b0);
          exp_rdy_q.push_back(i == 7);
        end
      end
    end
  endtask

  // Sends n bytes back-to-back with dv held high (junk on din while rdy is low).
  // abort_at > 0 asserts reset in that cycle of the stream.
  task automatic apply_stimulus(input string tag, input int n,
                                input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input int abort_at);
    logic [7:0] bytes [3];
    logic e_so, e_rdy;
    int nxt, cyc;
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
    push_model(n, bytes);
    @(negedge clk);
    din = bytes[0];
    dv  = 1'b1;
    nxt = 1;
    cyc = 0;
    while (exp_so_q.size() > 0) begin
      @(negedge clk);
      cyc++;
      if (cyc == abort_at) begin
        rst = 1'b1;
        dv  = 1'b0;
        #1;
        check_output({tag, " abort so"},   so,   1'b1);
        check_output({tag, " abort rdy"},  rdy,  1'b1);
        check_output({tag, " abort busy"}, busy, 1'b0);
        exp_so_q.delete();
        exp_rdy_q.delete();
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      e_so  = exp_so_q.pop_front();
      e_rdy = exp_rdy_q.pop_front();
      check_output($sformatf("%s c%0d so", tag, cyc),   so,   e_so);
      check_output($sformatf("%s c%0d rdy", tag, cyc),  rdy,  e_rdy);
      check_output($sformatf("%s c%0d busy", tag, cyc), busy, 1'b1);
      if (nxt < n) begin
        din = e_rdy ? bytes[nxt] : 8'($urandom);
        dv  = 1'b1;
        if (e_rdy) nxt++;
      end else begin
        din = 8'($urandom);
        dv  = 1'b0;
      end
    end
    @(negedge clk);
    check_output({tag, " idle so"},   so,   1'b1);
    check_output({tag, " idle rdy"},  rdy,  1'b1);
    check_output({tag, " idle busy"}, busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    din = 8'h00;
    dv  = 1'b0;
    #1;
    check_output("reset so",   so,   1'b1);
    check_output("reset rdy",  rdy,  1'b1);
    check_output("reset busy", busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_output($sformatf("idle%0d so", i), so, 1'b1);
      check_output($sformatf("idle%0d busy", i), busy, 1'b0);
    end

    $display("[TB] single bytes");
    apply_stimulus("b00", 1, 8'h00, 8'h00, 8'h00, 0);
    apply_stimulus("bFF", 1, 8'hFF, 8'h00, 8'h00, 0);
    $display("[TB] back-to-back streams");
    apply_stimulus("x801F", 2, 8'h80, 8'h1F, 8'h00, 0);
    apply_stimulus("x55AA", 2, 8'h55, 8'hAA, 8'h00, 0);
    apply_stimulus("xFFFF", 3, 8'hFF, 8'hFF, 8'h7C, 0);
    apply_stimulus("xF8", 2, 8'hF8, 8'h03, 8'h00, 0);
    $display("[TB] reset mid-byte");
    apply_stimulus("abort00", 1, 8'h00, 8'h00, 8'h00, 4);
    apply_stimulus("bF0", 1, 8'hF0, 8'h00, 8'h00, 0);
    apply_stimulus("abortFF", 1, 8'hFF, 8'h00, 8'h00, 4);
    apply_stimulus("b0F", 1, 8'h0F, 8'h00, 8'h00, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
